instr_fetch_unit: RTL and testbench

//   Instruction fetch stage upstream of the main decoder. Holds the PC and fetches one
//   32-bit word per request from instruction memory, using a variable-latency req/ack

---
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per request over a
// variable-latency req/ack port and hands it to the decoder via valid/ready.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_C = {RESET_PC[31:2], 2'b00};
    localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        imem_req_q, imem_req_d;
    logic        fetch_err_q, fetch_err_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;
    logic [31:0] tgt_s;
    logic        timeout_s;

    assign tgt_s     = {redirect_target[31:2], 2'b00};
    assign timeout_s = ((wait_cnt_q + 8'd1) == MAX_WAIT_C);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC_C;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            fetch_err_q   <= 1'b0;
            wait_cnt_q    <= 8'd0;
            redir_pend_q  <= 1'b0;
            redir_tgt_q   <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            fetch_err_q   <= fetch_err_d;
            wait_cnt_q    <= wait_cnt_d;
            redir_pend_q  <= redir_pend_d;
            redir_tgt_q   <= redir_tgt_d;
        end
    end

    // Next-state logic; a redirect seen during or before the ack discards the data
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    if (redir_pend_q || redirect) state_d = S_REQ;
                    else                          state_d = S_HOLD;
                end else if (timeout_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect || instr_ready) state_d = S_REQ;
                else                         state_d = S_HOLD;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // PC, captured word, wait counter and pending-redirect bookkeeping
    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        wait_cnt_d   = wait_cnt_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        case (state_q)
            S_REQ: begin
                if (imem_ack) begin
                    wait_cnt_d   = 8'd0;
                    redir_pend_d = 1'b0;
                    if (redirect)          pc_d    = tgt_s;
                    else if (redir_pend_q) pc_d    = redir_tgt_q;
                    else                   instr_d = imem_rdata;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (redirect) begin
                        redir_pend_d = 1'b1;
                        redir_tgt_d  = tgt_s;
                    end else begin
                        redir_pend_d = redir_pend_q;
                    end
                end
            end
            S_HOLD: begin
                wait_cnt_d = 8'd0;
                if (redirect) begin
                    pc_d    = tgt_s;
                    instr_d = 32'h0000_0000;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    instr_d = 32'h0000_0000;
                end else begin
                    pc_d    = pc_q;
                end
            end
            S_ERR:   instr_d = 32'h0000_0000;
            default: wait_cnt_d = 8'd0;
        endcase
    end

    // Registered handshake/status outputs decoded from the next state
    always_comb begin
        imem_req_d    = (state_d == S_REQ);
        instr_valid_d = (state_d == S_HOLD);
        fetch_err_d   = (state_d == S_ERR);
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a default instance plus one built with
// RESET_PC=32'hFFFF_FFFC and MAX_WAIT=4, both driven from the same inputs.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;

    logic        req_a, valid_a, err_a;
    logic [31:0] addr_a, instr_a, pc_a, pc4_a;
    logic        req_b, valid_b, err_b;
    logic [31:0] addr_b, instr_b, pc_b, pc4_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr_a), .instr_valid(valid_a), .instr_ready(instr_ready),
        .pc_out(pc_a), .pc_plus4(pc4_a),
        .redirect(redirect), .redirect_target(redirect_target), .fetch_err(err_a)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr_b), .instr_valid(valid_b), .instr_ready(instr_ready),
        .pc_out(pc_b), .pc_plus4(pc4_b),
        .redirect(redirect), .redirect_target(redirect_target), .fetch_err(err_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
        redirect_target = 32'h0; imem_rdata = 32'h0;
        step(); step();
        n_checks++;
        if ({req_a, valid_a, err_a, addr_a, instr_a} !== {3'b000, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_a: req/valid/err=%b%b%b addr=%h instr=%h, want 000 0 0",
                     req_a, valid_a, err_a, addr_a, instr_a);
        end
        n_checks++;
        if ({req_b, valid_b, err_b, addr_b} !== {3'b000, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL reset_b: req/valid/err=%b%b%b addr=%h, want 000 fffffffc",
                     req_b, valid_b, err_b, addr_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        logic [31:0] word;
        test_reset();
        imem_ack = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            word = 32'hA500_0000 + 32'(k);
            imem_rdata = word;
            step();
            n_checks++;
            if ({req_a, valid_a, addr_a} !== {2'b10, 32'(4 * k)}) begin
                n_fail++;
                $display("FAIL zw_req%0d: req=%b valid=%b addr=%h, want 1 0 %h",
                         k, req_a, valid_a, addr_a, 32'(4 * k));
            end
            step();
            n_checks++;
            if ({req_a, valid_a, instr_a, pc_a, pc4_a} !== {2'b01, word, 32'(4 * k), 32'(4 * k + 4)}) begin
                n_fail++;
                $display("FAIL zw_data%0d: req=%b valid=%b instr=%h pc=%h pc4=%h, want 0 1 %h %h %h",
                         k, req_a, valid_a, instr_a, pc_a, pc4_a, word, 32'(4 * k), 32'(4 * k + 4));
            end
        end
    endtask

    task automatic test_latency();
        test_reset();
        step();
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({req_a, valid_a, addr_a} !== {2'b10, 32'h0}) begin
                n_fail++;
                $display("FAIL lat_wait%0d: req=%b valid=%b addr=%h, want 1 0 0", c, req_a, valid_a, addr_a);
            end
            if (c == 2) begin
                imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
            end
            if (c < 2) step();
        end
        step();
        imem_ack = 1'b0;
        n_checks++;
        if ({valid_a, instr_a[31:26], instr_a, pc_a} !== {1'b1, 6'b100011, 32'h8C22_0004, 32'h0}) begin
            n_fail++;
            $display("FAIL lat_data: valid=%b instr=%h pc=%h, want 1 8c220004 0", valid_a, instr_a, pc_a);
        end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if ({req_a, valid_a, instr_a, pc_a} !== {2'b01, 32'h8C22_0004, 32'h0}) begin
                n_fail++;
                $display("FAIL hold%0d: req=%b valid=%b instr=%h pc=%h, want 0 1 8c220004 0",
                         c, req_a, valid_a, instr_a, pc_a);
            end
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        n_checks++;
        if ({req_a, valid_a, addr_a, instr_a} !== {2'b10, 32'h4, 32'h0}) begin
            n_fail++;
            $display("FAIL hold_release: req=%b valid=%b addr=%h instr=%h, want 1 0 4 0",
                     req_a, valid_a, addr_a, instr_a);
        end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_target = 32'h0000_0043;
        step();
        redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        n_checks++;
        if ({req_a, addr_a} !== {1'b1, 32'h4}) begin
            n_fail++;
            $display("FAIL redir_inflight: req=%b addr=%h, want 1 4", req_a, addr_a);
        end
        step();
        imem_rdata = 32'h1234_5678;
        n_checks++;
        if ({req_a, valid_a, addr_a} !== {2'b10, 32'h40}) begin
            n_fail++;
            $display("FAIL redir_discard: req=%b valid=%b addr=%h, want 1 0 40", req_a, valid_a, addr_a);
        end
        step();
        imem_ack = 1'b0;
        n_checks++;
        if ({valid_a, instr_a, pc_a} !== {1'b1, 32'h1234_5678, 32'h40}) begin
            n_fail++;
            $display("FAIL redir_fetch: valid=%b instr=%h pc=%h, want 1 12345678 40", valid_a, instr_a, pc_a);
        end
        redirect = 1'b1; redirect_target = 32'h0000_0100;
        step();
        n_checks++;
        if ({req_a, valid_a, addr_a} !== {2'b10, 32'h100}) begin
            n_fail++;
            $display("FAIL redir_hold: req=%b valid=%b addr=%h, want 1 0 100", req_a, valid_a, addr_a);
        end
        redirect_target = 32'h0000_0203; imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        step();
        redirect = 1'b0; imem_rdata = 32'h0BAD_F00D;
        n_checks++;
        if ({req_a, valid_a, addr_a} !== {2'b10, 32'h200}) begin
            n_fail++;
            $display("FAIL redir_same_cycle: req=%b valid=%b addr=%h, want 1 0 200", req_a, valid_a, addr_a);
        end
        step();
        imem_ack = 1'b0;
        n_checks++;
        if ({valid_a, instr_a, pc_a, pc4_a} !== {1'b1, 32'h0BAD_F00D, 32'h200, 32'h204}) begin
            n_fail++;
            $display("FAIL redir_after: valid=%b instr=%h pc=%h pc4=%h, want 1 0badf00d 200 204",
                     valid_a, instr_a, pc_a, pc4_a);
        end
    endtask

    task automatic test_wrap();
        test_reset();
        n_checks++;
        if (pc4_b !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_reset_pc4: pc_plus4=%h, want 0", pc4_b);
        end
        imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 32'h0000_0020;
        step();
        n_checks++;
        if ({req_b, addr_b} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_first: req=%b addr=%h, want 1 fffffffc", req_b, addr_b);
        end
        step();
        n_checks++;
        if ({valid_b, pc_b, pc4_b} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_data: valid=%b pc=%h pc4=%h, want 1 fffffffc 0", valid_b, pc_b, pc4_b);
        end
        step();
        n_checks++;
        if ({req_b, addr_b} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_second: req=%b addr=%h, want 1 0", req_b, addr_b);
        end
    endtask

    task automatic test_timeout();
        test_reset();
        for (int c = 1; c <= 4; c++) begin
            step();
            n_checks++;
            if ({req_b, err_b} !== 2'b10) begin
                n_fail++;
                $display("FAIL tmo_wait%0d: req=%b err=%b, want 1 0", c, req_b, err_b);
            end
        end
        step();
        n_checks++;
        if ({req_b, valid_b, err_b} !== 3'b001) begin
            n_fail++;
            $display("FAIL tmo_err: req=%b valid=%b err=%b, want 0 0 1", req_b, valid_b, err_b);
        end
        step(); step();
        n_checks++;
        if ({req_b, err_b} !== 2'b01) begin
            n_fail++;
            $display("FAIL tmo_sticky: req=%b err=%b, want 0 1", req_b, err_b);
        end
        #2 rst_n = 1'b0; imem_ack = 1'b1;
        #1;
        n_checks++;
        if ({req_b, err_b, addr_b} !== {2'b00, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL tmo_async_rst: req=%b err=%b addr=%h, want 0 0 fffffffc", req_b, err_b, addr_b);
        end
        step();
        n_checks++;
        if ({req_b, valid_b, err_b} !== 3'b000) begin
            n_fail++;
            $display("FAIL tmo_late_ack: req=%b valid=%b err=%b, want 0 0 0", req_b, valid_b, err_b);
        end
        rst_n = 1'b1; imem_ack = 1'b0;
        step();
        n_checks++;
        if ({req_b, err_b, addr_b} !== {2'b10, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL tmo_restart: req=%b err=%b addr=%h, want 1 0 fffffffc", req_b, err_b, addr_b);
        end
    endtask

    initial begin
        test_zero_wait();
        test_latency();
        test_hold();
        test_redirect();
        test_wrap();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
